// File: rtl/muldiv_unit_e.sv
// muldiv_unit_e
//   Execute-stage multi-cycle multiply/divide engine. Produces HI/LO for
//   MULT/MULTU/DIV/DIVU and holds the E stage through alu_stall until the
//   result is ready.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   op_valid, op       mul/div instruction in E; 00 MULT 01 MULTU 10 DIV 11 DIVU
//   src_a, src_b       rs / rt operands, sampled only at issue
//   flush              exception flush, aborts any operation
//   stall_ext          E held by another source; keeps a finished result parked
//   alu_stall          stall request to the hazard unit
//   result_valid       hi/lo valid for the instruction in E this cycle
//   hi, lo             product high/low or remainder/quotient
module muldiv_unit_e #(
    parameter int WIDTH    = 32,
    parameter int DIV_CNTW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             flush,
    input  logic             stall_ext,
    output logic             alu_stall,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state, state_nx;
    logic [DIV_CNTW-1:0]  cnt;
    // a_q holds the multiplicand for MUL and doubles as the quotient shift
    // register for DIV (dividend bits shift out as quotient bits shift in).
    logic [WIDTH-1:0]     a_q, b_q, rem_q;
    logic                 mul_signed, q_neg, r_neg;

    logic                 issue, signed_div;
    logic [WIDTH-1:0]     a_mag, b_mag;

    assign issue      = (state == IDLE) && op_valid && !flush;
    assign signed_div = (op == 2'b10);
    // Divide works on magnitudes; multiply keeps raw operands.
    assign a_mag = (signed_div && src_a[WIDTH-1]) ? -src_a : src_a;
    assign b_mag = (signed_div && src_b[WIDTH-1]) ? -src_b : src_b;

    // 33x33 signed multiply done as a 2W x 2W product of sign/zero-extended
    // operands; the low 2W bits are identical.
    logic [2*WIDTH-1:0] mul_a, mul_b, prod;
    assign mul_a = {{WIDTH{mul_signed & a_q[WIDTH-1]}}, a_q};
    assign mul_b = {{WIDTH{mul_signed & b_q[WIDTH-1]}}, b_q};
    assign prod  = mul_a * mul_b;

    // One restoring-division step. With a zero divisor the compare always
    // succeeds, giving an all-ones quotient and the dividend as remainder.
    logic [WIDTH:0]   rem_sh, diff;
    logic             ge;
    logic [WIDTH-1:0] rem_nx, quo_nx;
    assign rem_sh = {rem_q, a_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, b_q};
    assign ge     = (rem_sh >= {1'b0, b_q});
    assign rem_nx = ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign quo_nx = {a_q[WIDTH-2:0], ge};

    always_comb begin
        state_nx     = state;
        alu_stall    = 1'b0;
        result_valid = 1'b0;
        case (state)
            IDLE: if (issue) begin
                alu_stall = 1'b1;
                state_nx  = op[1] ? DIV : MUL;
            end
            MUL: begin
                alu_stall = 1'b1;
                state_nx  = DONE;
            end
            DIV: begin
                alu_stall = 1'b1;
                if (cnt == '1) state_nx = DONE;
            end
            DONE: begin
                result_valid = 1'b1;
                if (!stall_ext) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (flush) begin
            alu_stall    = 1'b0;
            result_valid = 1'b0;
            state_nx     = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            mul_signed <= 1'b0;
            q_neg      <= 1'b0;
            r_neg      <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            state <= state_nx;
            if (flush || issue)   cnt <= '0;
            else if (state == DIV) cnt <= cnt + 1'b1;

            if (issue) begin
                a_q        <= a_mag;
                b_q        <= b_mag;
                rem_q      <= '0;
                mul_signed <= ~op[0];
                q_neg      <= signed_div & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                r_neg      <= signed_div & src_a[WIDTH-1];
            end

            // hi/lo change only on completion, so a flush leaves them intact.
            if (!flush && state == MUL) begin
                hi <= prod[2*WIDTH-1:WIDTH];
                lo <= prod[WIDTH-1:0];
            end

            if (!flush && state == DIV) begin
                a_q   <= quo_nx;
                rem_q <= rem_nx;
                if (cnt == '1) begin
                    hi <= r_neg ? -rem_nx : rem_nx;
                    lo <= q_neg ? -quo_nx : quo_nx;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit_e.sv
// Directed bench for muldiv_unit_e: a vector table of ops with hand-computed
// HI/LO and stall counts, plus sequences for flush, stall_ext hold and reset.
module tb_muldiv_unit_e;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic [1:0]  op;
    logic [31:0] src_a, src_b;
    logic        flush, stall_ext;
    logic        alu_stall, result_valid;
    logic [31:0] hi, lo;

    int errors = 0;
    int checks = 0;

    muldiv_unit_e #(.WIDTH(32), .DIV_CNTW(5)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush), .stall_ext(stall_ext),
        .alu_stall(alu_stall), .result_valid(result_valid), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b;
        logic [31:0] exp_hi, exp_lo;
        int          stalls;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Issues an op in the current (IDLE) cycle, counts stall cycles until
    // result_valid, checks the result, optionally holds DONE with stall_ext,
    // then steps into the following IDLE cycle (where the next op may issue).
    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input int stalls, input int hold);
        int n;
        bit got;
        n = 0;
        got = 0;
        op = o; src_a = a; src_b = b; op_valid = 1'b1;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (result_valid) begin
                got = 1;
                break;
            end
            if (alu_stall) n++;
            @(negedge clk);
            // operands must have been sampled at issue only
            op_valid = 1'b0; src_a = ~a; src_b = ~b;
            #1;
        end
        chk({name, " done"}, 32'(got), 32'd1);
        chk({name, " stalls"}, n, stalls);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
        if (hold > 0) begin
            stall_ext = 1'b1;
            op_valid  = 1'b1;
            src_a = 32'd3; src_b = 32'd5; op = 2'b00;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                if (h == hold - 1) stall_ext = 1'b0;
                #1;
                chk({name, " hold valid"}, 32'(result_valid), 32'd1);
                chk({name, " hold stall"}, 32'(alu_stall), 32'd0);
                chk({name, " hold hi"}, hi, eh);
                chk({name, " hold lo"}, lo, el);
            end
        end
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        chk({name, " idle valid"}, 32'(result_valid), 32'd0);
        chk({name, " idle stall"}, 32'(alu_stall), 32'd0);
    endtask

    initial begin
        int seen;
        vecs[0] = '{2'b00, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 2};
        vecs[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2};
        vecs[2] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2};
        vecs[3] = '{2'b01, 32'h80000000, 32'h00000002, 32'h00000001, 32'h00000000, 2};
        vecs[4] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[5] = '{2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 33};
        vecs[6] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[7] = '{2'b11, 32'hFFFFFFFF, 32'd10,       32'd5,        32'h19999999, 33};
        vecs[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vecs[9] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'h00000001, 33};

        rst = 1'b1; op_valid = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        flush = 1'b0; stall_ext = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset alu_stall", 32'(alu_stall), 32'd0);
        chk("reset result_valid", 32'(result_valid), 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // back-to-back: each op issues in the IDLE cycle following the previous DONE
        for (int i = 0; i < 10; i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].stalls, 0);

        // flush wins over op_valid in IDLE
        op_valid = 1'b1; op = 2'b00; src_a = 32'd2; src_b = 32'd2; flush = 1'b1;
        #1;
        chk("flush issue stall", 32'(alu_stall), 32'd0);
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flush issue not started", 32'(alu_stall), 32'd0);

        // flush at DIV iteration 10 (cycle 11 after issue)
        op_valid = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd3;
        repeat (11) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        #1;
        chk("pre-flush stall", 32'(alu_stall), 32'd1);
        flush = 1'b1;
        #1;
        chk("flush stall", 32'(alu_stall), 32'd0);
        chk("flush valid", 32'(result_valid), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("post-flush hi kept", hi, 32'hFFFFFFF9);
        chk("post-flush lo kept", lo, 32'h00000001);
        run_op("mult after flush", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 2, 0);

        // stall_ext holds DONE for 3 cycles
        run_op("divu hold", 2'b11, 32'd50, 32'd7, 32'd1, 32'd7, 33, 3);
        run_op("mult hold", 2'b00, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, 2, 3);

        // reset mid-DIV
        op_valid = 1'b1; op = 2'b11; src_a = 32'd77; src_b = 32'd5;
        repeat (5) begin
            @(negedge clk);
            op_valid = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst stall", 32'(alu_stall), 32'd0);
        chk("midrst valid", 32'(result_valid), 32'd0);
        chk("midrst hi", hi, 32'd0);
        chk("midrst lo", lo, 32'd0);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (result_valid || alu_stall) seen++;
        end
        chk("midrst no result", seen, 0);
        run_op("after rst", 2'b11, 32'd77, 32'd5, 32'd2, 32'd15, 33, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
